otp_uart_tx: RTL
================

Name: otp_uart_tx

Overview:
Serialises the current 16-bit OTP to a host terminal over an 8N1 UART line. This is the delivery end of the OTP path: the LFSR generates the code, the entry FSM checks user digits against it, and this block sends the same code out.
Each request sends six characters: four uppercase ASCII hex digits, MS nibble first, then CR and LF.
It sits beside the 7-segment driver in the top level and takes the LFSR output plus a one-cycle send strobe.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range >= 2
NUM_CHARS, 6, characters per frame (4 hex + CR + LF); fixed, exposed for bench visibility only

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
otp  input  16  OTP value; sampled only when a send is accepted
send  input  1  request strobe; accepted only when busy=0
tx  output  1  UART serial line; idle high
busy  output  1  high from the cycle after acceptance until the frame completes
done  output  1  one-cycle pulse when the last stop bit has finished

Behaviour:
- Reset (reset=0, asynchronous):
  - tx=1, busy=0, done=0, all counters and state cleared.
  - Takes effect immediately, including mid-bit or mid-frame.
  - Nothing partial is resumed after release; the block waits in IDLE.
- Acceptance:
  - send=1 while busy=0 latches otp into a 16-bit shadow register and clears the char index.
  - Next cycle: busy=1, and tx=0 begins the first start bit. Latency is 1 cycle. All outputs are registered.
- Character mapping, per nibble:
  - 0x0-0x9 -> 0x30-0x39.
  - 0xA-0xF -> 0x41-0x46.
  - Order: otp[15:12], otp[11:8], otp[7:4], otp[3:0], 0x0D, 0x0A.
- Bit framing:
  - Each bit holds for exactly CLKS_PER_BIT cycles.
  - Order: start (0), data bits 0..7 (LSB first), stop (1).
  - No idle gap between characters; the next start bit follows the stop bit directly.
  - Full frame = 60*CLKS_PER_BIT cycles of busy.
- Top FSM states, with transitions:
  - IDLE -> LOAD on an accepted send.
  - LOAD (one internal cycle, fused with the first start bit) -> SEND_CHAR.
  - SEND_CHAR -> NEXT on the byte sub-module's byte_done.
  - NEXT -> SEND_CHAR if char index < 5, otherwise -> FINISH.
  - FINISH -> IDLE. In FINISH, done=1 and busy=0 for exactly one cycle.
  - NEXT must not add cycles on tx; the char mux is precomputed.
- Boundary conditions:
  - send while busy=1: ignored, not queued, no effect on the frame in flight.
  - send in the done cycle: accepted, because busy=0. The new frame's start bit begins the next cycle, giving a back-to-back frame with no idle bit.
  - otp changes after acceptance: no effect; the shadow register is used.
  - The baud counter wraps at CLKS_PER_BIT-1. Counter width is $clog2(CLKS_PER_BIT). The bit counter is 4 bits, 0..9.
  - The char index is 3 bits, 0..5. Index values 6 and 7 are unreachable; if they occur, the FSM goes to IDLE with tx=1.
- No X on outputs at any time after reset is asserted.

Decomposition:
- Shared package (otp_pkg):
  - ASCII_CR=8'h0D, ASCII_LF=8'h0A, ASCII_0=8'h30, ASCII_A_MINUS_10=8'h37.
  - NUM_CHARS=6.
  - Top FSM state enum (IDLE, LOAD, SEND_CHAR, NEXT, FINISH).
  - nibble_to_ascii function.
- One sub-module: uart_tx_byte.
  - Ports: clk, reset, start, data[7:0], tx, byte_done, busy.
  - Has its own baud and bit counters and its own START/DATA/STOP states.
  - byte_done pulses on the final cycle of the stop bit, so the parent can issue the next start bit on the following cycle with no gap.
- The top block holds the shadow register, the char index, the char mux and the frame FSM.

Test Plan:
- Bench runs with CLKS_PER_BIT=4.
- Reset: hold reset=0 for 3 cycles -> tx=1, busy=0, done=0; after release with send=0 for 50 cycles -> outputs stay the same.
- Basic frame: otp=16'h3A7F, send pulse -> decoded bytes 0x33,0x41,0x37,0x46,0x0D,0x0A; busy high for exactly 240 cycles; done high for exactly 1 cycle; each bit exactly 4 cycles wide.
- Digit extremes: otp=16'h09AF -> bytes 0x30,0x39,0x41,0x46,0x0D,0x0A. otp=16'h0000 -> bytes 0x30 x4, then CR and LF.
- Ignore while busy / latching: during a frame for 16'h1234, pulse send and change otp to 16'hFFFF -> frame still 0x31,0x32,0x33,0x34,CR,LF; no second frame follows.
- Back-to-back: send asserted in the done cycle with otp=16'hBEEF -> tx=0 on the next cycle; second frame 0x42,0x45,0x45,0x46,CR,LF; no idle bit between frames.
- Reset mid-frame: assert reset=0 during the data bits of char 2 -> tx=1 and busy=0 in the same cycle (asynchronous); after release a new send produces a complete, correct frame.

Source files
------------

// File: rtl/otp_pkg.sv
// Shared definitions for the OTP UART delivery path.
//   - ASCII constants used to render the code on a terminal
//   - NUM_CHARS  : characters per frame (4 hex digits + CR + LF)
//   - otp_state_e: frame-level FSM states of otp_uart_tx
//   - nibble_to_ascii: maps one hex nibble to its uppercase ASCII digit
package otp_pkg;

    localparam logic [7:0] ASCII_CR         = 8'h0D;
    localparam logic [7:0] ASCII_LF         = 8'h0A;
    localparam logic [7:0] ASCII_0          = 8'h30;
    localparam logic [7:0] ASCII_A_MINUS_10 = 8'h37;

    localparam int NUM_CHARS = 6;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND_CHAR,
        NEXT,
        FINISH
    } otp_state_e;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_0 + {4'h0, nib};
        end
        return ASCII_A_MINUS_10 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 UART transmitter.
//   clk       : system clock
//   reset     : asynchronous, active-low reset
//   start     : begin a byte; honoured when idle or on the final stop-bit cycle
//   abort     : synchronous return to idle with the line high
//   data[7:0] : byte to send; read live at each bit boundary, so the caller
//               must hold it stable for the whole byte
//   tx        : registered serial line, idle high
//   byte_done : high on the final cycle of the stop bit
//   busy      : high while a byte is on the line
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] data,
    output logic       tx,
    output logic       byte_done,
    output logic       busy
);

    localparam int                BAUD_W   = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        B_IDLE,
        B_START,
        B_DATA,
        B_STOP
    } byte_state_e;

    byte_state_e       state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [3:0]        bit_q, bit_d;      // 0 = start, 1..8 = data, 9 = stop
    logic              tx_q, tx_d;
    logic              baud_wrap;

    assign baud_wrap = (baud_q == BAUD_MAX);

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        byte_done = 1'b0;

        case (state_q)
            B_IDLE: begin
                tx_d = 1'b1;
                if (start) begin
                    state_d = B_START;
                    baud_d  = '0;
                    bit_d   = 4'd0;
                    tx_d    = 1'b0;
                end
            end
            B_START: begin
                baud_d = baud_wrap ? '0 : baud_q + BAUD_W'(1);
                if (baud_wrap) begin
                    state_d = B_DATA;
                    bit_d   = 4'd1;
                    tx_d    = data[0];
                end
            end
            B_DATA: begin
                baud_d = baud_wrap ? '0 : baud_q + BAUD_W'(1);
                if (baud_wrap) begin
                    bit_d = bit_q + 4'd1;
                    if (bit_q == 4'd8) begin
                        state_d = B_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        // bit_q = k is sending data[k-1]; next is data[k]
                        tx_d = data[bit_q[2:0]];
                    end
                end
            end
            B_STOP: begin
                baud_d = baud_wrap ? '0 : baud_q + BAUD_W'(1);
                if (baud_wrap) begin
                    byte_done = 1'b1;
                    bit_d     = 4'd0;
                    // A start on the last stop cycle chains the next byte
                    // with no idle time on the line.
                    if (start) begin
                        state_d = B_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = B_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = B_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (abort) begin
            state_d   = B_IDLE;
            baud_d    = '0;
            bit_d     = 4'd0;
            tx_d      = 1'b1;
            byte_done = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= B_IDLE;
            baud_q  <= '0;
            bit_q   <= 4'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != B_IDLE);

endmodule

// File: rtl/otp_uart_tx.sv
// Sends the current 16-bit OTP to a terminal as "HHHH\r\n" over 8N1 UART.
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   otp   : OTP value, captured into a shadow register when a send is accepted
//   send  : request strobe, accepted only while busy is low
//   tx    : serial line, idle high
//   busy  : high from the cycle after acceptance until the frame completes
//   done  : one-cycle pulse after the final stop bit
module otp_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int NUM_CHARS    = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] otp,
    input  logic        send,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    import otp_pkg::*;

    localparam logic [2:0] LAST_IDX = 3'(NUM_CHARS - 1);

    otp_state_e  state_q, state_d;
    logic [15:0] shadow_q, shadow_d;
    logic [2:0]  char_idx_q, char_idx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        accept;
    logic        byte_start;
    logic        byte_abort;
    logic        byte_done;
    logic        byte_busy;
    logic [7:0]  char_byte;

    // busy_q is low in IDLE and FINISH, so a send in the done cycle is taken.
    assign accept = send && !busy_q;

    // Character for the current index, settled before each byte starts so
    // chaining to the next character costs no line time.
    always_comb begin
        char_byte = 8'h00;
        case (char_idx_q)
            3'd0:    char_byte = nibble_to_ascii(shadow_q[15:12]);
            3'd1:    char_byte = nibble_to_ascii(shadow_q[11:8]);
            3'd2:    char_byte = nibble_to_ascii(shadow_q[7:4]);
            3'd3:    char_byte = nibble_to_ascii(shadow_q[3:0]);
            3'd4:    char_byte = ASCII_CR;
            3'd5:    char_byte = ASCII_LF;
            default: char_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        char_idx_d = char_idx_q;
        byte_start = 1'b0;
        byte_abort = 1'b0;

        case (state_q)
            IDLE, FINISH: begin
                state_d = IDLE;
                if (accept) begin
                    // Start bit goes out on the very next cycle.
                    state_d    = LOAD;
                    shadow_d   = otp;
                    char_idx_d = 3'd0;
                    byte_start = 1'b1;
                end
            end
            LOAD: begin
                state_d = SEND_CHAR;
            end
            SEND_CHAR: begin
                if (!byte_busy) begin
                    // Byte engine lost its frame; do not wait forever.
                    state_d    = IDLE;
                    byte_abort = 1'b1;
                end else if (byte_done) begin
                    if (char_idx_q < LAST_IDX) begin
                        // Next start bit is issued on the final stop cycle;
                        // NEXT is the first cycle of that start bit.
                        state_d    = NEXT;
                        char_idx_d = char_idx_q + 3'd1;
                        byte_start = 1'b1;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            NEXT: begin
                state_d = SEND_CHAR;
            end
            default: begin
                state_d    = IDLE;
                byte_abort = 1'b1;
            end
        endcase

        // Indices past the last character cannot occur in normal operation;
        // drop the frame and park the line high if one ever appears.
        if ((state_q == LOAD || state_q == SEND_CHAR || state_q == NEXT) &&
            (char_idx_q > LAST_IDX)) begin
            state_d    = IDLE;
            char_idx_d = 3'd0;
            byte_start = 1'b0;
            byte_abort = 1'b1;
        end

        busy_d = (state_d == LOAD) || (state_d == SEND_CHAR) || (state_d == NEXT);
        done_d = (state_d == FINISH);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            shadow_q   <= 16'h0000;
            char_idx_q <= 3'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            char_idx_q <= char_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk       (clk),
        .reset     (reset),
        .start     (byte_start),
        .abort     (byte_abort),
        .data      (char_byte),
        .tx        (tx),
        .byte_done (byte_done),
        .busy      (byte_busy)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule
